// File: rtl/core_pkg.sv
// Shared types and constants for the core's pipeline control logic.
package core_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FLUSH   = 2'd1,
    RX_WAIT = 2'd2,
    TX_WAIT = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module hazard_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: load-use stalls, taken-branch
// flushes and blocking UART accesses in EX. Control only, no datapath.
module pipeline_hazard_ctrl
  import core_pkg::*;
#(
  parameter int unsigned REG_W       = core_pkg::REG_W,
  parameter int unsigned FLUSH_DEPTH = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_valid,
  input  logic             ex_MemRead,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_UARTtoReg,
  input  logic             ex_RegtoUART,
  input  logic             branch_taken,
  input  logic             uart_rx_valid,
  input  logic             uart_tx_ready,
  output logic             pc_enable,
  output logic             inst_enable,
  output logic             distinct,
  output logic             ex_bubble,
  output logic             ex_hold,
  output logic             uart_rx_ack,
  output logic             uart_tx_we,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

  ctrl_state_t     r_state;
  ctrl_state_t     w_state_nxt;
  logic [FC_W-1:0] r_flush_cnt;
  logic [FC_W-1:0] w_flush_cnt_nxt;
  logic            w_load_use;
  logic            w_rx_req;
  logic            w_tx_req;
  logic            w_flush_inc;
  logic            w_stall_inc;

  // Load-use: EX load writes a register that ID is about to read.
  always_comb begin
    w_load_use = 1'b0;
    if (id_valid && ex_valid && ex_MemRead && (ex_dst != REG_W'(ZERO_REG))) begin
      w_load_use = (id_uses_rs && (id_rs == ex_dst)) ||
                   (id_uses_rt && (id_rt == ex_dst));
    end
  end

  assign w_rx_req = ex_valid && ex_UARTtoReg;
  assign w_tx_req = ex_valid && ex_RegtoUART && !ex_UARTtoReg;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    pc_enable       = 1'b1;
    inst_enable     = 1'b1;
    distinct        = 1'b1;
    ex_bubble       = 1'b0;
    ex_hold         = 1'b0;
    uart_rx_ack     = 1'b0;
    uart_tx_we      = 1'b0;
    w_flush_inc     = 1'b0;
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;

    if (reset) begin
      pc_enable       = 1'b0;
      inst_enable     = 1'b0;
      distinct        = 1'b0;
      ex_bubble       = 1'b1;
      w_state_nxt     = RUN;
      w_flush_cnt_nxt = '0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_rx_req && !uart_rx_valid) begin
            pc_enable   = 1'b0;
            inst_enable = 1'b0;
            ex_hold     = 1'b1;
            w_state_nxt = RX_WAIT;
          end else if (w_tx_req && !uart_tx_ready) begin
            pc_enable   = 1'b0;
            inst_enable = 1'b0;
            ex_hold     = 1'b1;
            w_state_nxt = TX_WAIT;
          end else begin
            uart_rx_ack = w_rx_req;
            uart_tx_we  = w_tx_req;
            if (ex_valid && branch_taken) begin
              distinct    = 1'b0;
              ex_bubble   = 1'b1;
              w_flush_inc = 1'b1;
              if (FLUSH_DEPTH > 1) begin
                w_state_nxt     = FLUSH;
                w_flush_cnt_nxt = FC_W'(FLUSH_DEPTH - 1);
              end
            end else if (w_load_use) begin
              // One cycle suffices: the bubble entering EX clears the match.
              pc_enable   = 1'b0;
              inst_enable = 1'b0;
              ex_bubble   = 1'b1;
            end
          end
        end
        FLUSH: begin
          distinct        = 1'b0;
          ex_bubble       = 1'b1;
          w_flush_cnt_nxt = r_flush_cnt - FC_W'(1);
          if (r_flush_cnt <= FC_W'(1)) begin
            w_state_nxt = RUN;
          end
        end
        RX_WAIT: begin
          if (uart_rx_valid) begin
            uart_rx_ack = 1'b1;
            w_state_nxt = RUN;
          end else begin
            pc_enable   = 1'b0;
            inst_enable = 1'b0;
            ex_hold     = 1'b1;
          end
        end
        TX_WAIT: begin
          if (uart_tx_ready) begin
            uart_tx_we  = 1'b1;
            w_state_nxt = RUN;
          end else begin
            pc_enable   = 1'b0;
            inst_enable = 1'b0;
            ex_hold     = 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  assign w_stall_inc = !reset && !pc_enable;

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK     (CLK),
    .reset   (reset),
    .i_inc   (w_stall_inc),
    .o_count (stall_cycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK     (CLK),
    .reset   (reset),
    .i_inc   (w_flush_inc),
    .o_count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned FLUSH_DEPTH = 2;
  localparam int unsigned CNT_W       = 32;

  logic             CLK = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             ex_valid;
  logic             ex_MemRead;
  logic [REG_W-1:0] ex_dst;
  logic             ex_UARTtoReg;
  logic             ex_RegtoUART;
  logic             branch_taken;
  logic             uart_rx_valid;
  logic             uart_tx_ready;
  logic             pc_enable;
  logic             inst_enable;
  logic             distinct;
  logic             ex_bubble;
  logic             ex_hold;
  logic             uart_rx_ack;
  logic             uart_tx_we;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(
    .REG_W       (REG_W),
    .FLUSH_DEPTH (FLUSH_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .ex_valid      (ex_valid),
    .ex_MemRead    (ex_MemRead),
    .ex_dst        (ex_dst),
    .ex_UARTtoReg  (ex_UARTtoReg),
    .ex_RegtoUART  (ex_RegtoUART),
    .branch_taken  (branch_taken),
    .uart_rx_valid (uart_rx_valid),
    .uart_tx_ready (uart_tx_ready),
    .pc_enable     (pc_enable),
    .inst_enable   (inst_enable),
    .distinct      (distinct),
    .ex_bubble     (ex_bubble),
    .ex_hold       (ex_hold),
    .uart_rx_ack   (uart_rx_ack),
    .uart_tx_we    (uart_tx_we),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: which UART side we are blocked on (0 none, 1 rx, 2 tx) and how
  // many post-branch invalid fetches are still owed.
  int     m_wait       = 0;
  int     m_flush_left = 0;
  longint m_stalls     = 0;
  longint m_flushes    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    id_valid      = 1'b0;
    id_rs         = '0;
    id_rt         = '0;
    id_uses_rs    = 1'b0;
    id_uses_rt    = 1'b0;
    ex_valid      = 1'b0;
    ex_MemRead    = 1'b0;
    ex_dst        = '0;
    ex_UARTtoReg  = 1'b0;
    ex_RegtoUART  = 1'b0;
    branch_taken  = 1'b0;
    uart_rx_valid = 1'b0;
    uart_tx_ready = 1'b0;
  endtask

  // Called just after a falling edge with inputs set: check outputs, advance model.
  task automatic tick();
    logic e_pc, e_inst, e_dist, e_bub, e_hold, e_ack, e_we;
    bit   hazard, rx_blk, tx_blk, flush_ev;
    int   nxt_wait, nxt_flush;
    #1;
    e_pc = 1; e_inst = 1; e_dist = 1; e_bub = 0; e_hold = 0; e_ack = 0; e_we = 0;
    flush_ev  = 0;
    nxt_wait  = m_wait;
    nxt_flush = m_flush_left;
    hazard = id_valid && ex_valid && ex_MemRead && (ex_dst != 0) &&
             ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    if (reset) begin
      e_pc = 0; e_inst = 0; e_dist = 0; e_bub = 1;
      nxt_wait = 0; nxt_flush = 0;
    end else if (m_wait == 1 || m_wait == 2) begin
      if ((m_wait == 1) ? uart_rx_valid : uart_tx_ready) begin
        if (m_wait == 1) e_ack = 1; else e_we = 1;
        nxt_wait = 0;
      end else begin
        e_pc = 0; e_inst = 0; e_hold = 1;
      end
    end else if (m_flush_left > 0) begin
      e_dist = 0; e_bub = 1;
      nxt_flush = m_flush_left - 1;
    end else begin
      rx_blk = ex_valid && ex_UARTtoReg && !uart_rx_valid;
      tx_blk = ex_valid && !ex_UARTtoReg && ex_RegtoUART && !uart_tx_ready;
      if (rx_blk || tx_blk) begin
        e_pc = 0; e_inst = 0; e_hold = 1;
        nxt_wait = rx_blk ? 1 : 2;
      end else begin
        if (ex_valid && ex_UARTtoReg) e_ack = 1;
        else if (ex_valid && ex_RegtoUART) e_we = 1;
        if (ex_valid && branch_taken) begin
          e_dist = 0; e_bub = 1; flush_ev = 1;
          nxt_flush = FLUSH_DEPTH - 1;
        end else if (hazard) begin
          e_pc = 0; e_inst = 0; e_bub = 1;
        end
      end
    end
    chk("pc_enable",    64'(pc_enable),    64'(e_pc));
    chk("inst_enable",  64'(inst_enable),  64'(e_inst));
    chk("distinct",     64'(distinct),     64'(e_dist));
    chk("ex_bubble",    64'(ex_bubble),    64'(e_bub));
    chk("ex_hold",      64'(ex_hold),      64'(e_hold));
    chk("uart_rx_ack",  64'(uart_rx_ack),  64'(e_ack));
    chk("uart_tx_we",   64'(uart_tx_we),   64'(e_we));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_stalls));
    chk("flush_count",  64'(flush_count),  64'(m_flushes));
    if (reset) begin
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      if (!e_pc) m_stalls++;
      if (flush_ev) m_flushes++;
    end
    m_wait       = nxt_wait;
    m_flush_left = nxt_flush;
    @(negedge CLK);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    @(negedge CLK);
    @(negedge CLK);

    // Reset held for three checked cycles
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Load-use on rs: single stall cycle
    id_valid = 1; id_uses_rs = 1; id_rs = 5'd8;
    ex_valid = 1; ex_MemRead = 1; ex_dst = 5'd8;
    tick();
    ex_valid = 0;
    tick();
    chk("lu_stall_total", 64'(stall_cycles), 64'd1);

    // Load to r0 and unused rt never stall
    idle();
    id_valid = 1; id_uses_rs = 1; ex_valid = 1; ex_MemRead = 1;
    tick();
    id_rs = 5'd3; id_rt = 5'd8; id_uses_rs = 1; id_uses_rt = 0; ex_dst = 5'd8;
    tick();

    // Taken branch: two invalid fetches
    idle();
    ex_valid = 1; branch_taken = 1;
    tick();
    idle();
    tick();
    tick();
    chk("br_flush_total", 64'(flush_count), 64'd1);

    // Blocking RX for five cycles, then data arrives
    idle();
    ex_valid = 1; ex_UARTtoReg = 1;
    repeat (5) tick();
    uart_rx_valid = 1;
    tick();
    idle();
    tick();

    // Branch together with load-use: flush takes priority
    ex_valid = 1; branch_taken = 1; ex_MemRead = 1; ex_dst = 5'd8;
    id_valid = 1; id_uses_rs = 1; id_rs = 5'd8;
    tick();
    idle();
    repeat (2) tick();

    // Reset while waiting on RX: no ack survives
    ex_valid = 1; ex_UARTtoReg = 1;
    repeat (2) tick();
    reset = 1; uart_rx_valid = 1;
    tick();
    reset = 0; ex_valid = 0; ex_UARTtoReg = 0;
    tick();

    // Blocking TX, two cycles then ready
    idle();
    ex_valid = 1; ex_RegtoUART = 1;
    repeat (2) tick();
    uart_tx_ready = 1;
    tick();
    idle();
    tick();

    // Random traffic with small register space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs         = REG_W'($urandom_range(0, 3));
      id_rt         = REG_W'($urandom_range(0, 3));
      id_uses_rs    = $urandom_range(0, 1) != 0;
      id_uses_rt    = $urandom_range(0, 1) != 0;
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_MemRead    = ($urandom_range(0, 2) == 0);
      ex_dst        = REG_W'($urandom_range(0, 3));
      ex_UARTtoReg  = ($urandom_range(0, 9) == 0);
      ex_RegtoUART  = ($urandom_range(0, 9) == 0);
      branch_taken  = ($urandom_range(0, 7) == 0);
      uart_rx_valid = ($urandom_range(0, 2) == 0);
      uart_tx_ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
